// File: rtl/memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_pkg                                                         |
// | Shared types and defaults for the latency-programmable word memory |
// | responder and its storage array.                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package memory_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;
  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int COUNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/memory_responder_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_responder_array                                             |
// | Synchronous single-port word array. One access per enabled edge:  |
// | a write updates the word, a read registers the word on rdata.     |
// | Contents and read register are intentionally not reset.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module memory_responder_array
  import memory_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] rdata_q;

  // Single port: the enabled edge either writes the word or latches it for reading.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule : memory_responder_array
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_responder                                                   |
// | Valid/ready word memory target with a fixed access latency.       |
// | IDLE accepts one request, BUSY counts down the latency, RESPOND   |
// | holds the response until the initiator takes it.                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module memory_responder
  import memory_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  requestValid,
  output logic                  requestReady,
  input  logic                  requestWrite,
  input  logic [WORD_WIDTH-1:0] requestAddress,
  input  logic [WORD_WIDTH-1:0] requestData,
  output logic                  responseValid,
  input  logic                  responseReady,
  output logic [WORD_WIDTH-1:0] responseData,
  output logic                  responseError
);

  localparam int                  IDX_W        = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0]  C_LOAD       = COUNT_W'(LATENCY - 1);
  localparam logic [COUNT_W-1:0]  C_ONE        = COUNT_W'(1);
  localparam logic [WORD_WIDTH:0] C_BYTE_LIMIT = (WORD_WIDTH + 1)'(4 * DEPTH);

  state_t                  state_q, state_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic                    write_q, write_d;
  logic [WORD_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    ready_q, ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_error_q, resp_error_d;
  logic                    resp_read_q, resp_read_d;

  logic                    addr_err;
  logic                    access_en;
  logic [WORD_WIDTH-1:0]   arr_rdata;

  // Misaligned or beyond the array: such a request never touches storage.
  assign addr_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= C_BYTE_LIMIT);

  // Next-state, counter and response-flag logic for the three-state FSM.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    resp_read_d  = resp_read_q;
    access_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (requestValid && ready_q) begin
          write_d = requestWrite;
          addr_d  = requestAddress;
          data_d  = requestData;
          count_d = C_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count_q == '0) begin
          access_en    = 1'b1;
          state_d      = RESPOND;
          resp_valid_d = 1'b1;
          resp_error_d = addr_err;
          resp_read_d  = !write_q && !addr_err;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
      RESPOND: begin
        if (responseReady) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_error_d = 1'b0;
          resp_read_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Ready is registered from the next state, so responseReady never reaches it combinationally.
    ready_d = (state_d == IDLE);
  end

  // State and response registers; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_read_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_read_q  <= resp_read_d;
    end
  end

  memory_responder_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (access_en && !addr_err),
    .we    (write_q),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (data_q),
    .rdata (arr_rdata)
  );

  assign requestReady  = ready_q;
  assign responseValid = resp_valid_q;
  assign responseError = resp_error_q;
  // The array's read register only moves on an enabled read, so it is stable through RESPOND.
  assign responseData  = resp_read_q ? arr_rdata : '0;

endmodule : memory_responder
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_memory_responder                                                |
// | Self-checking bench: directed vector table, randomized traffic    |
// | against a word-array reference model, reset abort and LATENCY=1   |
// | back-to-back sequences.                                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_memory_responder;

  localparam int LAT   = 2;
  localparam int WORDS = 256;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic        requestValid = 1'b0, requestWrite = 1'b0, responseReady = 1'b0;
  logic [31:0] requestAddress = '0, requestData = '0;
  logic        requestReady, responseValid, responseError;
  logic [31:0] responseData;

  logic        requestValid1 = 1'b0, requestWrite1 = 1'b0, responseReady1 = 1'b0;
  logic [31:0] requestAddress1 = '0, requestData1 = '0;
  logic        requestReady1, responseValid1, responseError1;
  logic [31:0] responseData1;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH(WORDS), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .requestValid   (requestValid),
    .requestReady   (requestReady),
    .requestWrite   (requestWrite),
    .requestAddress (requestAddress),
    .requestData    (requestData),
    .responseValid  (responseValid),
    .responseReady  (responseReady),
    .responseData   (responseData),
    .responseError  (responseError)
  );

  memory_responder #(.DEPTH(WORDS), .LATENCY(1)) dut1 (
    .clk            (clk),
    .reset          (reset),
    .requestValid   (requestValid1),
    .requestReady   (requestReady1),
    .requestWrite   (requestWrite1),
    .requestAddress (requestAddress1),
    .requestData    (requestData1),
    .responseValid  (responseValid1),
    .responseReady  (responseReady1),
    .responseData   (responseData1),
    .responseError  (responseError1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: plain word array plus a "has been written" flag.
  logic [31:0] ref_mem   [WORDS];
  bit          ref_known [WORDS];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          err;
    logic [31:0] rd;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                                      output bit err, output logic [31:0] rd, output bit known);
    int unsigned idx;
    err   = (a % 4 != 0) || (a >= 32'(4 * WORDS));
    rd    = '0;
    known = 1'b1;
    if (!err) begin
      idx = a / 4;
      if (w) begin
        ref_mem[idx]   = d;
        ref_known[idx] = 1'b1;
      end else begin
        rd    = ref_mem[idx];
        known = ref_known[idx];
      end
    end
  endfunction

  // One complete transaction on the LATENCY=2 instance, with checks throughout.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit exp_err, input logic [31:0] exp_data, input bit chk_data,
                        input int hold, input string name);
    int waited;
    int lat;
    @(negedge clk);
    requestValid   = 1'b1;
    requestWrite   = w;
    requestAddress = a;
    requestData    = d;
    waited = 0;
    while (!requestReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!requestReady) begin
      chk({name, "_accept_timeout"}, 32'(requestReady), 32'd1);
      requestValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble the request lines after acceptance; the captured request must win.
    requestValid   = 1'b0;
    requestWrite   = ~w;
    requestAddress = $urandom;
    requestData    = $urandom;
    lat = 0;
    while (!responseValid && lat < 20) begin
      responseReady = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    responseReady = 1'b0;
    chk({name, "_latency"}, 32'(lat), 32'(LAT));
    if (!responseValid) return;
    chk({name, "_error"}, 32'(responseError), 32'(exp_err));
    if (chk_data) chk({name, "_data"}, responseData, exp_data);
    chk({name, "_busy_ready"}, 32'(requestReady), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, 32'(responseValid), 32'd1);
      chk({name, "_hold_error"}, 32'(responseError), 32'(exp_err));
      if (chk_data) chk({name, "_hold_data"}, responseData, exp_data);
      chk({name, "_hold_ready"}, 32'(requestReady), 32'd0);
    end
    responseReady = 1'b1;
    @(posedge clk); #1;
    responseReady = 1'b0;
    chk({name, "_release_valid"}, 32'(responseValid), 32'd0);
    chk({name, "_release_ready"}, 32'(requestReady), 32'd1);
  endtask

  // LATENCY=1 instance with request and response handshakes held high.
  task automatic back_to_back();
    int acc_c[$];
    int rsp_c[$];
    bit pv;
    bit acc;
    requestValid1   = 1'b1;
    requestWrite1   = 1'b1;
    requestAddress1 = 32'h40;
    responseReady1  = 1'b1;
    pv = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      acc = requestReady1;
      requestData1 = $urandom;
      @(posedge clk); #1;
      if (acc) acc_c.push_back(c);
      if (responseValid1 && !pv) begin
        rsp_c.push_back(c);
        chk("b2b_error", 32'(responseError1), 32'd0);
      end
      pv = responseValid1;
    end
    requestValid1  = 1'b0;
    responseReady1 = 1'b0;
    chk("b2b_enough_accepts", 32'(acc_c.size() >= 5), 32'd1);
    chk("b2b_count", 32'(rsp_c.size()), 32'(acc_c.size()));
    for (int i = 0; i < acc_c.size() && i < rsp_c.size(); i++) begin
      chk($sformatf("b2b_resp_lat%0d", i), 32'(rsp_c[i] - acc_c[i]), 32'd1);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'(acc_c[i] - acc_c[i-1] >= 3), 32'd1);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    bit          m_err;
    bit          m_known;
    logic [31:0] m_rd;
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    int unsigned sel;
    int          waited;

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF, 0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 32'h0,          1});
    vecs.push_back('{1'b0, 32'h0000_0003, 32'h0,          1'b1, 32'h0,          0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'hA5A5_0001, 0});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h0,          0});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0,          5});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,          1'b0, 32'h0BAD_F00D, 2});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,          1'b1, 32'h0,          0});
    vecs.push_back('{1'b1, 32'h0000_0012, 32'h7777_7777, 1'b1, 32'h0,          0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 32'h0,          0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,          1'b0, 32'h1111_2222, 0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF, 0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'hA5A5_0001, 0});

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  32'(requestReady),  32'd0);
    chk("rst_valid",  32'(responseValid), 32'd0);
    chk("rst_data",   responseData,       32'd0);
    chk("rst_error",  32'(responseError), 32'd0);
    chk("rst_ready1", 32'(requestReady1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(requestReady), 32'd1);

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].err, vecs[i].rd, 1'b1,
             vecs[i].hold, $sformatf("vec%0d", i));
      model_apply(vecs[i].w, vecs[i].a, vecs[i].d, m_err, m_rd, m_known);
    end

    // Reset in the middle of BUSY on a write to 0x20
    @(negedge clk);
    requestValid   = 1'b1;
    requestWrite   = 1'b1;
    requestAddress = 32'h20;
    requestData    = 32'h1234_5678;
    waited = 0;
    while (!requestReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("abort_accept", 32'(requestReady), 32'd1);
    @(posedge clk); #1;
    requestValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_valid_in_rst", 32'(responseValid), 32'd0);
    chk("abort_ready_in_rst", 32'(requestReady),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_resp%0d", c), 32'(responseValid), 32'd0);
    end
    chk("abort_ready_after", 32'(requestReady), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 1'b0, 32'h1111_2222, 1'b1, 0, "abort_readback");

    // Randomized traffic against the reference model
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 6) a = 32'($urandom_range(0, WORDS - 1)) * 4;
      else if (sel == 7) a = (32'($urandom_range(0, WORDS - 1)) * 4) | 32'($urandom_range(1, 3));
      else               a = 32'h400 | $urandom;
      w = 1'($urandom);
      d = $urandom;
      model_apply(w, a, d, m_err, m_rd, m_known);
      do_req(w, a, d, m_err, m_rd, m_known, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // LATENCY=1 back-to-back
    back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_memory_responder
`default_nettype wire

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameters: DEPTH, default 256, number of 32-bit words; LATENCY, default 2, cycles from request acceptance to response, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 requestValid  input  1  initiator presents a request.
REQ-005 requestReady  output  1  responder can accept a request.
REQ-006 requestWrite  input  1  1 = write, 0 = read.
REQ-007 requestAddress  input  32  byte address.
REQ-008 requestData  input  32  write data.
REQ-009 responseValid  output  1  response available.
REQ-010 responseReady  input  1  initiator consumes the response.
REQ-011 responseData  output  32  read data; 0 for writes and errors.
REQ-012 responseError  output  1  the request was misaligned or out of range.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, BUSY, RESPOND.
REQ-014 requestReady SHALL be 1 only in IDLE; a request SHALL be accepted on the edge where requestValid and requestReady are both 1.
REQ-015 On acceptance the block SHALL register write, address and data, load the counter with LATENCY-1, and enter BUSY; later changes on the request inputs SHALL be ignored.
REQ-016 In BUSY, at each edge: if counter = 0, perform the access and enter RESPOND; otherwise decrement the counter.
REQ-017 responseValid SHALL rise exactly LATENCY edges after the acceptance edge.
REQ-018 Word index = address[log2(DEPTH)+1:2].
REQ-019 A request is an error if address[1:0] != 0 or address >= 4*DEPTH; an error SHALL write nothing, and SHALL give responseData = 0 and responseError = 1.
REQ-020 A valid write SHALL update the array on the BUSY->RESPOND edge; responseData = 0.
REQ-021 A valid read SHALL capture the array word on the BUSY->RESPOND edge into responseData.
REQ-022 In RESPOND, responseValid, responseData and responseError SHALL be held stable until an edge with responseReady = 1; that edge SHALL return to IDLE and clear responseValid.
REQ-023 There SHALL be no combinational path from responseReady to requestReady.
REQ-024 A new request SHALL be accepted no earlier than the edge after the return to IDLE.
REQ-025 Read-after-write to the same address SHALL return the new data.
REQ-026 responseReady asserted outside RESPOND SHALL be ignored.

Reset
REQ-027 reset SHALL force the state to IDLE and the counter to 0.
REQ-028 reset SHALL force requestReady = 0 while asserted, then 1 after deassertion.
REQ-029 reset SHALL force responseValid = 0, responseData = 0 and responseError = 0.
REQ-030 Array contents SHALL NOT be reset.
REQ-031 Reset in BUSY SHALL abort the access: no write occurs and no response is produced.
REQ-032 Reset in RESPOND SHALL drop the pending response.

Structure
REQ-033 A shared package memory_pkg SHALL hold the state enum (IDLE/BUSY/RESPOND), the default DEPTH and LATENCY, and the word width 32.
REQ-034 Storage SHALL be one sub-module, memory_responder_array: a synchronous single-port 32-bit word array with write enable; the FSM and counter stay in memory_responder.

Verification
REQ-035 LATENCY=2: write 0x0000_0010 <- 0xDEAD_BEEF, then read 0x10 -> each responseValid 2 cycles after acceptance; read data 0xDEAD_BEEF; error 0.
REQ-036 Read address 0x3 -> responseError=1, responseData=0; word 0 unchanged on a later read.
REQ-037 Write address 0x400 with DEPTH=256 -> responseError=1; no word is modified.
REQ-038 Hold responseReady=0 for 5 cycles in RESPOND -> outputs stable and requestReady=0 throughout; a single handshake then returns to IDLE.
REQ-039 LATENCY=1, back-to-back requests with requestValid held high -> acceptances separated by at least 3 cycles; each response arrives 1 cycle after its acceptance.
REQ-040 Assert reset mid-BUSY on a write of 0x1234_5678 to 0x20 -> no response; the following read of 0x20 returns the prior value.
